mem_bus_responder: RTL and testbench
====================================

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 SHALL have parameter ADDRESSSIZE, default 32, setting the address and data word width in bits.
REQ-002 SHALL have parameter MEM_INDEX_BITS, default 10, giving 2^MEM_INDEX_BITS words of storage, indexed by Address_Com[MEM_INDEX_BITS-1:0].
REQ-003 SHALL have parameter MEM_LATENCY, default 4, giving the access latency in cycles; legal range 1..15.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous and active-low.
REQ-006 Mem_Rd  input  1  read request from the cache holding the common-bus grant; level, held until served.
REQ-007 Mem_Wr  input  1  write-back request from the granted cache; level, held until acknowledged.
REQ-008 Address_Com  input  ADDRESSSIZE  common-bus address; valid while Mem_Rd or Mem_Wr is high.
REQ-009 Data_Bus_Com  inout  ADDRESSSIZE  common-bus data; driven only in DRIVE, high-Z otherwise.
REQ-010 Data_in_Bus  inout  1  data-valid strobe; driven 1 in DRIVE, high-Z otherwise; sampled as input in LATENCY.
REQ-011 Mem_Wr_Ack  output  1  one-cycle pulse at write commit.
REQ-012 Mem_busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement the states IDLE, LATENCY, DRIVE, WRITE and RELEASE.
REQ-014 IDLE: Mem_Rd=1 -> capture the index and start req_is_rd=1; the latency counter loads MEM_LATENCY-1; the block enters LATENCY.
REQ-015 IDLE: Mem_Wr=1 with Mem_Rd=0 -> capture the index and Data_Bus_Com; the latency counter loads MEM_LATENCY-1; the block enters LATENCY with req_is_rd=0.
REQ-016 If Mem_Rd and Mem_Wr are both 1 in IDLE, the read SHALL win; the write stays pending and is served afterwards.
REQ-017 LATENCY: the counter decrements each cycle; at 0 the block enters DRIVE (read) or WRITE (write).
REQ-018 The first cycle of DRIVE SHALL come exactly MEM_LATENCY cycles after the Mem_Rd sampling edge.
REQ-019 LATENCY, read only: if Data_in_Bus is sampled 1 (a cache-to-cache supplier), the access SHALL be aborted and the block enters RELEASE; the memory never drives data.
REQ-020 DRIVE: drive Data_Bus_Com=mem[index] and Data_in_Bus=1; remain in DRIVE while Mem_Rd=1; Mem_Rd=0 -> RELEASE.
REQ-021 WRITE: commit mem[index] from the captured data; pulse Mem_Wr_Ack=1 for one cycle; enter RELEASE.
REQ-022 RELEASE: exactly one cycle with all bus outputs high-Z and no new request accepted (bus turnaround); then IDLE.
REQ-023 Address_Com bits above MEM_INDEX_BITS-1 SHALL be ignored; the index wraps modulo depth.
REQ-024 Changes to Address_Com or Mem_Rd/Mem_Wr after capture SHALL NOT affect the access in progress, except deassertion of Mem_Rd during DRIVE.
REQ-025 Deassertion of Mem_Rd during LATENCY SHALL still complete the read to DRIVE; the block leaves DRIVE the next cycle because Mem_Rd=0.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, clear the counter, set Mem_busy=0 and Mem_Wr_Ack=0, and float Data_Bus_Com and Data_in_Bus; this applies in any state, including mid-access.
REQ-027 Reset SHALL NOT clear storage contents; a write aborted by reset before WRITE SHALL leave memory unchanged.

Verification
REQ-028 Mem_Wr=1, Address_Com=0x0000_0010, Data_Bus_Com=0xDEAD_BEEF -> Mem_Wr_Ack pulses exactly 5 cycles after sampling (MEM_LATENCY=4); then Mem_Rd on the same address -> Data_in_Bus=1, Data_Bus_Com=0xDEAD_BEEF from the 4th cycle after sampling.
REQ-029 Read of 0x0000_0410 with MEM_INDEX_BITS=10 -> returns the word at index 0x010 (wrap-around).
REQ-030 Read started, then another agent drives Data_in_Bus=1 during cycle 2 of LATENCY -> responder never drives Data_Bus_Com; returns to IDLE after one RELEASE cycle.
REQ-031 Mem_Rd and Mem_Wr asserted together -> read served first; the write is acknowledged after RELEASE; Mem_busy is continuous except for one IDLE sampling cycle.
REQ-032 rst_n=0 in DRIVE -> next edge: bus high-Z, Mem_busy=0; previously written data still reads back after reset.
REQ-033 MEM_LATENCY=1 -> DRIVE on the cycle following the sampling edge; back-to-back reads are separated by exactly one RELEASE cycle.

Source files
------------

// File: rtl/mem_bus_responder.sv
// Memory-side responder on the shared cache bus: serves reads after a fixed
// latency, commits write-backs, and yields when another cache supplies the data.
module mem_bus_responder #(
  parameter int ADDRESSSIZE    = 32,
  parameter int MEM_INDEX_BITS = 10,
  parameter int MEM_LATENCY    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   Mem_Rd,
  input  logic                   Mem_Wr,
  input  logic [ADDRESSSIZE-1:0] Address_Com,
  inout  wire  [ADDRESSSIZE-1:0] Data_Bus_Com,
  inout  wire                    Data_in_Bus,
  output logic                   Mem_Wr_Ack,
  output logic                   Mem_busy
);
  localparam int DEPTH = 1 << MEM_INDEX_BITS;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LATENCY = 3'd1,
    DRIVE   = 3'd2,
    WRITE   = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [CNT_W-1:0]          lat_cnt;
  logic                      req_is_rd;
  logic [MEM_INDEX_BITS-1:0] idx;
  logic [ADDRESSSIZE-1:0]    wr_data;
  logic [ADDRESSSIZE-1:0]    mem [DEPTH];
  logic                      drive_en;
  logic                      accept;
  logic                      unused_addr;

  // Only IDLE accepts; a simultaneous read and write resolves to the read.
  assign accept      = (state == IDLE) && (Mem_Rd || Mem_Wr);
  assign unused_addr = ^Address_Com;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Mem_Rd || Mem_Wr) state_nxt = LATENCY;
      LATENCY: begin
        // A cache-to-cache supplier raising the strobe pre-empts our read.
        if (req_is_rd && Data_in_Bus) begin
          state_nxt = RELEASE;
        end else if (lat_cnt == '0) begin
          state_nxt = req_is_rd ? DRIVE : WRITE;
        end
      end
      DRIVE:   if (!Mem_Rd) state_nxt = RELEASE;
      WRITE:   state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Mem_busy = (state != IDLE);
    drive_en = (state == DRIVE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_cnt    <= '0;
      req_is_rd  <= 1'b0;
      Mem_Wr_Ack <= 1'b0;
    end else begin
      Mem_Wr_Ack <= (state == WRITE);
      if (accept) begin
        lat_cnt   <= CNT_W'(MEM_LATENCY - 1);
        req_is_rd <= Mem_Rd;
      end else if (state == LATENCY && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
    end
  end

  // Storage and captured request are data: reset never touches them, but a
  // commit is suppressed on a reset edge so an interrupted write leaves no trace.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      idx     <= Address_Com[MEM_INDEX_BITS-1:0];
      wr_data <= Data_Bus_Com;
    end
    if (rst_n && state == WRITE) begin
      mem[idx] <= wr_data;
    end
  end

  assign Data_Bus_Com = drive_en ? mem[idx] : {ADDRESSSIZE{1'bz}};
  assign Data_in_Bus  = drive_en ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized bench for mem_bus_responder: a word-array model of storage plus
// latency arithmetic predicts every strobe, data word and acknowledge.
module tb_mem_bus_responder;
  localparam int AW    = 32;
  localparam int IB    = 10;
  localparam int LAT   = 4;
  localparam int DEPTH = 1 << IB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] addr;
  logic [AW-1:0] tb_data;
  logic          tb_data_en, tb_strb_en;
  tri   [AW-1:0] data_bus;
  tri            data_in_bus;
  logic          wr_ack, busy;

  assign data_bus    = tb_data_en ? tb_data : {AW{1'bz}};
  assign data_in_bus = tb_strb_en ? 1'b1 : 1'bz;

  mem_bus_responder #(.ADDRESSSIZE(AW), .MEM_INDEX_BITS(IB), .MEM_LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .Mem_Rd(mem_rd), .Mem_Wr(mem_wr),
    .Address_Com(addr), .Data_Bus_Com(data_bus), .Data_in_Bus(data_in_bus),
    .Mem_Wr_Ack(wr_ack), .Mem_busy(busy)
  );

  logic          rd1, wr1;
  logic [AW-1:0] addr1;
  logic [AW-1:0] tb_data1;
  logic          tb_data1_en;
  tri   [AW-1:0] data_bus1;
  tri            strobe1;
  logic          ack1, busy1;

  assign data_bus1 = tb_data1_en ? tb_data1 : {AW{1'bz}};

  mem_bus_responder #(.ADDRESSSIZE(AW), .MEM_INDEX_BITS(IB), .MEM_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .Mem_Rd(rd1), .Mem_Wr(wr1),
    .Address_Com(addr1), .Data_Bus_Com(data_bus1), .Data_in_Bus(strobe1),
    .Mem_Wr_Ack(ack1), .Mem_busy(busy1)
  );

  logic [AW-1:0] ref_mem  [DEPTH];
  logic [AW-1:0] ref_mem1 [DEPTH];
  logic [AW-1:0] wlist [$];

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // A bus counts as released when no bit is actively driven high.
  function automatic bit is_float(input logic [AW-1:0] v);
    for (int i = 0; i < AW; i++) if (v[i] === 1'b1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Tasks start and end at a negedge with the responder idle.
  task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] d);
    int n;
    n = -1;
    check_val("wr_pre_idle", 64'(busy), 64'd0);
    mem_wr = 1'b1; addr = a; tb_data = d; tb_data_en = 1'b1;
    cyc();
    tb_data_en = 1'b0;
    addr = $urandom;
    for (int j = 0; j <= 12; j++) begin
      if (wr_ack) begin n = j; break; end
      cyc();
    end
    check_val("wr_ack_lat", 64'(n), 64'(LAT + 1));
    check_val("wr_ack_busy", 64'(busy), 64'd1);
    mem_wr = 1'b0;
    cyc();
    check_val("wr_ack_pulse", 64'(wr_ack), 64'd0);
    check_val("wr_post_idle", 64'(busy), 64'd0);
    ref_mem[a[IB-1:0]] = d;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int hold);
    int n;
    logic [AW-1:0] exp;
    n   = -1;
    exp = ref_mem[a[IB-1:0]];
    check_val("rd_pre_idle", 64'(busy), 64'd0);
    mem_rd = 1'b1; addr = a;
    cyc();
    addr = $urandom;
    for (int j = 0; j <= 20; j++) begin
      if (data_in_bus === 1'b1) begin n = j; break; end
      check_val("rd_lat_float", 64'(is_float(data_bus)), 64'd1);
      cyc();
    end
    check_val("rd_lat", 64'(n), 64'(LAT));
    check_val("rd_data", 64'(data_bus), 64'(exp));
    for (int h = 0; h < hold; h++) begin
      cyc();
      check_val("rd_hold_strobe", 64'(data_in_bus === 1'b1), 64'd1);
      check_val("rd_hold_data", 64'(data_bus), 64'(exp));
    end
    mem_rd = 1'b0;
    cyc();
    check_val("rd_rel_busy", 64'(busy), 64'd1);
    check_val("rd_rel_float", 64'(is_float(data_bus)), 64'd1);
    check_val("rd_rel_strobe", 64'(data_in_bus === 1'b1), 64'd0);
    cyc();
    check_val("rd_post_idle", 64'(busy), 64'd0);
  endtask

  task automatic do_write_l1(input logic [AW-1:0] a, input logic [AW-1:0] d);
    int n;
    n = -1;
    wr1 = 1'b1; addr1 = a; tb_data1 = d; tb_data1_en = 1'b1;
    cyc();
    tb_data1_en = 1'b0;
    for (int j = 0; j <= 10; j++) begin
      if (ack1) begin n = j; break; end
      cyc();
    end
    check_val("l1_wr_ack_lat", 64'(n), 64'd2);
    wr1 = 1'b0;
    cyc();
    check_val("l1_wr_ack_pulse", 64'(ack1), 64'd0);
    ref_mem1[a[IB-1:0]] = d;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a, b, d, old, rnd;
    int lowcnt, idle_at, ack_at, n;

    rst_n = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; addr = '0;
    tb_data = '0; tb_data_en = 1'b0; tb_strb_en = 1'b0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; tb_data1 = '0; tb_data1_en = 1'b0;
    @(negedge clk);
    repeat (3) cyc();
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_ack", 64'(wr_ack), 64'd0);
    check_val("rst_float", 64'(is_float(data_bus)), 64'd1);
    check_val("rst_strobe", 64'(data_in_bus === 1'b1), 64'd0);
    check_val("rst_busy_l1", 64'(busy1), 64'd0);
    rst_n = 1'b1;
    cyc();

    // Directed write/read and index wrap-around.
    do_write(32'h0000_0010, 32'hDEAD_BEEF);
    do_read(32'h0000_0010, 0);
    do_read(32'h0000_0410, 1);

    // Randomized writes then aliased reads.
    for (int t = 0; t < 10; t++) begin
      a = $urandom;
      d = $urandom | 32'h1;
      do_write(a, d);
      wlist.push_back(a);
    end
    for (int t = 0; t < 12; t++) begin
      a   = wlist[$urandom_range(wlist.size() - 1)];
      rnd = $urandom;
      a   = {rnd[AW-1:IB], a[IB-1:0]};
      do_read(a, int'($urandom_range(2)));
    end

    // Cache-to-cache supplier aborts the read during the second latency cycle.
    a = wlist[0];
    mem_rd = 1'b1; addr = a;
    cyc();
    check_val("abort_float0", 64'(is_float(data_bus)), 64'd1);
    cyc();
    tb_strb_en = 1'b1; mem_rd = 1'b0;
    check_val("abort_float1", 64'(is_float(data_bus)), 64'd1);
    cyc();
    tb_strb_en = 1'b0;
    check_val("abort_rel_busy", 64'(busy), 64'd1);
    check_val("abort_rel_float", 64'(is_float(data_bus)), 64'd1);
    cyc();
    check_val("abort_idle", 64'(busy), 64'd0);
    for (int k = 0; k < LAT + 2; k++) begin
      cyc();
      check_val("abort_never_drive", 64'(data_in_bus === 1'b1), 64'd0);
    end

    // Read and write asserted together: read first, then the write.
    a   = wlist[1];
    old = ref_mem[a[IB-1:0]];
    d   = $urandom | 32'h1;
    mem_rd = 1'b1; mem_wr = 1'b1; addr = a; tb_data = d;
    lowcnt = 0;
    cyc();
    n = -1;
    for (int j = 0; j <= 20; j++) begin
      if (data_in_bus === 1'b1) begin n = j; break; end
      if (!busy) lowcnt++;
      cyc();
    end
    check_val("rw_rd_lat", 64'(n), 64'(LAT));
    check_val("rw_rd_data", 64'(data_bus), 64'(old));
    mem_rd = 1'b0;
    cyc();
    check_val("rw_rel_busy", 64'(busy), 64'd1);
    tb_data_en = 1'b1;
    idle_at = -1; ack_at = -1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (!busy) begin lowcnt++; if (idle_at < 0) idle_at = i; end
      if (wr_ack) begin ack_at = i; break; end
    end
    check_val("rw_busy_gaps", 64'(lowcnt), 64'd1);
    check_val("rw_ack_lat", 64'(ack_at - idle_at), 64'(LAT + 2));
    mem_wr = 1'b0; tb_data_en = 1'b0;
    ref_mem[a[IB-1:0]] = d;
    cyc();
    check_val("rw_post_idle", 64'(busy), 64'd0);
    do_read(a, 0);

    // Reset while driving read data.
    a = wlist[2];
    mem_rd = 1'b1; addr = a;
    cyc();
    for (int j = 0; j <= 20; j++) begin
      if (data_in_bus === 1'b1) break;
      cyc();
    end
    rst_n = 1'b0; mem_rd = 1'b0;
    cyc();
    check_val("rstd_busy", 64'(busy), 64'd0);
    check_val("rstd_ack", 64'(wr_ack), 64'd0);
    check_val("rstd_float", 64'(is_float(data_bus)), 64'd1);
    check_val("rstd_strobe", 64'(data_in_bus === 1'b1), 64'd0);
    rst_n = 1'b1;
    cyc();
    do_read(a, 0);

    // Write interrupted by reset mid-latency leaves storage unchanged.
    b = wlist[3];
    mem_wr = 1'b1; addr = b; tb_data = ~ref_mem[b[IB-1:0]]; tb_data_en = 1'b1;
    cyc();
    tb_data_en = 1'b0;
    cyc();
    rst_n = 1'b0; mem_wr = 1'b0;
    cyc();
    check_val("rstw_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 3; k++) begin
      cyc();
      check_val("rstw_no_ack", 64'(wr_ack), 64'd0);
    end
    do_read(b, 0);

    // Single-cycle latency instance: immediate drive and one-cycle turnaround.
    a = 32'h0000_0123;
    b = 32'h0000_0321;
    do_write_l1(a, 32'hCAFE_0001);
    do_write_l1(b, 32'h5A5A_A5A5);
    rd1 = 1'b1; addr1 = a;
    cyc();
    check_val("l1_lat_strobe", 64'(strobe1 === 1'b1), 64'd0);
    cyc();
    check_val("l1_drive_strobe", 64'(strobe1 === 1'b1), 64'd1);
    check_val("l1_drive_data", 64'(data_bus1), 64'(ref_mem1[a[IB-1:0]]));
    rd1 = 1'b0;
    cyc();
    check_val("l1_rel_busy", 64'(busy1), 64'd1);
    check_val("l1_rel_float", 64'(is_float(data_bus1)), 64'd1);
    rd1 = 1'b1; addr1 = b;
    cyc();
    check_val("l1_turnaround_idle", 64'(busy1), 64'd0);
    cyc();
    check_val("l1_rd2_lat", 64'(strobe1 === 1'b1), 64'd0);
    cyc();
    check_val("l1_rd2_strobe", 64'(strobe1 === 1'b1), 64'd1);
    check_val("l1_rd2_data", 64'(data_bus1), 64'(ref_mem1[b[IB-1:0]]));
    rd1 = 1'b0;
    cyc();
    cyc();
    check_val("l1_final_idle", 64'(busy1), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
